// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// Package     : light_pkg
// Description : Shared definitions for the traffic-light configurator and
//               the light FSM. Holds the sw mode codes, the configurator
//               state encoding and the duration range/default constants.
// Revision    : 1.0 - initial release
// ============================================================================
package light_pkg;

    // sw mode codes
    localparam logic [1:0] SW_RUN = 2'b00;
    localparam logic [1:0] SW_Y   = 2'b01;
    localparam logic [1:0] SW_G   = 2'b10;
    localparam logic [1:0] SW_R   = 2'b11;

    // Configurator state encoding
    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_RUN      = 3'd1,
        ST_EDIT_Y   = 3'd2,
        ST_EDIT_G   = 3'd3,
        ST_EDIT_R   = 3'd4,
        ST_COMMIT   = 3'd5
    } state_t;

    // Duration range and defaults, in ticks; also used by the light FSM
    localparam int LIGHT_DUR_W   = 4;
    localparam int LIGHT_DUR_MIN = 1;
    localparam int LIGHT_DUR_MAX = 7;
    localparam int LIGHT_G_DEF   = 4;
    localparam int LIGHT_Y_DEF   = 1;
    localparam int LIGHT_R_DEF   = 1;

    // Destination state for a given sw code (SW_RUN maps to RUN)
    function automatic state_t sw_to_state(input logic [1:0] sw_code);
        state_t st;
        case (sw_code)
            SW_Y:    st = ST_EDIT_Y;
            SW_G:    st = ST_EDIT_G;
            SW_R:    st = ST_EDIT_R;
            default: st = ST_RUN;
        endcase
        return st;
    endfunction

    function automatic logic is_edit(input state_t st);
        return (st == ST_EDIT_Y) || (st == ST_EDIT_G) || (st == ST_EDIT_R);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability counter. The
//               debounced level flips once the synchronised input has
//               differed from it for DEBOUNCE_CYC consecutive samples; a
//               1-cycle press pulse marks each rising edge of the level.
// Ports       : clk, rst (sync, active high)
//               i_btn   - raw asynchronous button
//               o_level - debounced level
//               o_press - 1-cycle pulse on rising edge of o_level
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int c_cnt_w = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_q;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            // Any sample that agrees with the current level restarts the run
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/light_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : light_timing_ctrl
// Description : Run-time configurator and sequencer for the two-way traffic
//               light FSM. Owns the live green/yellow/all-red durations,
//               lets the operator edit shadow copies with sw/btn, commits
//               them back, and generates the phase tick and run enable.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               sw[1:0]         - 00 run, 01 edit Y, 10 edit G, 11 edit R
//               btn[3:0]        - raw: inc, dec, restore field, restore all
//               dur_g/y/r       - live durations
//               tick_1s         - 1-cycle pulse every TICK_DIV cycles in RUN
//               run_en          - high in RUN only
//               cfg_commit      - 1-cycle pulse when shadows become live
//               led[3:0]        - shadow of the field being edited, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module light_timing_ctrl
    import light_pkg::*;
#(
    parameter int TICK_DIV     = 125_000_000,
    parameter int DEBOUNCE_CYC = 1_250_000,
    parameter int DUR_W        = LIGHT_DUR_W,
    parameter int DUR_MIN      = LIGHT_DUR_MIN,
    parameter int DUR_MAX      = LIGHT_DUR_MAX,
    parameter int G_DEF        = LIGHT_G_DEF,
    parameter int Y_DEF        = LIGHT_Y_DEF,
    parameter int R_DEF        = LIGHT_R_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sw,
    input  logic [3:0]       btn,
    output logic [DUR_W-1:0] dur_g,
    output logic [DUR_W-1:0] dur_y,
    output logic [DUR_W-1:0] dur_r,
    output logic             tick_1s,
    output logic             run_en,
    output logic             cfg_commit,
    output logic [3:0]       led
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    localparam logic [DUR_W-1:0] c_dur_min = DUR_W'(DUR_MIN);
    localparam logic [DUR_W-1:0] c_dur_max = DUR_W'(DUR_MAX);
    localparam logic [DUR_W-1:0] c_g_def   = DUR_W'(G_DEF);
    localparam logic [DUR_W-1:0] c_y_def   = DUR_W'(Y_DEF);
    localparam logic [DUR_W-1:0] c_r_def   = DUR_W'(R_DEF);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [DUR_W-1:0]    r_live_g, r_live_y, r_live_r;
    logic [DUR_W-1:0]    r_shd_g,  r_shd_y,  r_shd_r;
    logic [DUR_W-1:0]    w_sel_cur;
    logic [DUR_W-1:0]    w_sel_def;
    logic [DUR_W-1:0]    w_sel_nxt;
    logic                w_edit_act;
    logic [3:0]          w_press;
    // Debounced levels are not needed here; only press events drive edits
    logic [3:0]          w_unused_level;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn[gi]),
            .o_level (w_unused_level[gi]),
            .o_press (w_press[gi])
        );
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RST_WAIT: w_state_nxt = sw_to_state(sw);
            ST_RUN:      w_state_nxt = sw_to_state(sw);
            ST_EDIT_Y,
            ST_EDIT_G,
            ST_EDIT_R:   w_state_nxt = (sw == SW_RUN) ? ST_COMMIT : sw_to_state(sw);
            ST_COMMIT:   w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RST_WAIT;
        endcase
    end

    assign run_en     = (r_state == ST_RUN);
    assign cfg_commit = (r_state == ST_COMMIT);
    assign tick_1s    = (r_state == ST_RUN) && (r_tick_cnt == c_tick_last);

    // ------------------------------------------------------------------
    // Selected-field edit arithmetic and led mux
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_cur = r_shd_g;
        w_sel_def = c_g_def;
        case (r_state)
            ST_EDIT_Y: begin
                w_sel_cur = r_shd_y;
                w_sel_def = c_y_def;
            end
            ST_EDIT_R: begin
                w_sel_cur = r_shd_r;
                w_sel_def = c_r_def;
            end
            default: ;
        endcase

        // Highest-numbered button wins; restore-all is handled at write time
        w_sel_nxt = w_sel_cur;
        if (w_press[2]) begin
            w_sel_nxt = w_sel_def;
        end else if (w_press[1]) begin
            w_sel_nxt = (w_sel_cur > c_dur_min) ? w_sel_cur - 1'b1 : c_dur_min;
        end else if (w_press[0]) begin
            w_sel_nxt = (w_sel_cur < c_dur_max) ? w_sel_cur + 1'b1 : c_dur_max;
        end

        led = is_edit(r_state) ? 4'(w_sel_cur) : 4'd0;
    end

    // A press on the very cycle the FSM leaves for COMMIT is dropped so the
    // committed value is exactly what the operator last saw on the leds
    assign w_edit_act = is_edit(r_state) && (sw != SW_RUN) && (|w_press);

    // ------------------------------------------------------------------
    // Register file and tick prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_live_g   <= c_g_def;
            r_live_y   <= c_y_def;
            r_live_r   <= c_r_def;
            r_shd_g    <= c_g_def;
            r_shd_y    <= c_y_def;
            r_shd_r    <= c_r_def;
        end else begin
            if (r_state == ST_RUN) begin
                r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + 1'b1;
            end else begin
                r_tick_cnt <= '0;
            end

            // Entering edit from RUN starts from the live values
            if ((r_state == ST_RUN) && (sw != SW_RUN)) begin
                r_shd_g <= r_live_g;
                r_shd_y <= r_live_y;
                r_shd_r <= r_live_r;
            end

            if (r_state == ST_COMMIT) begin
                r_live_g <= r_shd_g;
                r_live_y <= r_shd_y;
                r_live_r <= r_shd_r;
            end

            if (w_edit_act) begin
                if (w_press[3]) begin
                    r_shd_g <= c_g_def;
                    r_shd_y <= c_y_def;
                    r_shd_r <= c_r_def;
                end else begin
                    case (r_state)
                        ST_EDIT_Y: r_shd_y <= w_sel_nxt;
                        ST_EDIT_R: r_shd_r <= w_sel_nxt;
                        default:   r_shd_g <= w_sel_nxt;
                    endcase
                end
            end
        end
    end

    assign dur_g = r_live_g;
    assign dur_y = r_live_y;
    assign dur_r = r_live_r;

endmodule
`default_nettype wire

// File: tb/tb_light_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_timing_ctrl
// Description : Scoreboard bench for light_timing_ctrl. Stimulus pushes the
//               expected led values and committed durations into queues; a
//               monitor pops them whenever led changes or cfg_commit fires,
//               and checks every tick_1s pulse against the RUN cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_timing_ctrl;

    localparam int TICK_DIV     = 10;
    localparam int DEBOUNCE_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [3:0] btn;
    logic [3:0] dur_g, dur_y, dur_r;
    logic       tick_1s, run_en, cfg_commit;
    logic [3:0] led;

    light_timing_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .dur_g      (dur_g),
        .dur_y      (dur_y),
        .dur_r      (dur_r),
        .tick_1s    (tick_1s),
        .run_en     (run_en),
        .cfg_commit (cfg_commit),
        .led        (led)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          tick_total = 0;
    int          commit_total = 0;
    logic [3:0]  q_led[$];
    logic [11:0] q_commit[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold long enough for sync + debounce, then release long enough to settle
    task automatic press(input logic [3:0] mask);
        btn = mask;
        cyc(8);
        btn = 4'b0000;
        cyc(10);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        logic [3:0]  prev_led;
        logic [11:0] exp_c;
        logic        commit_pend;
        int          run_cyc;
        prev_led    = 4'd0;
        exp_c       = '0;
        commit_pend = 1'b0;
        run_cyc     = 0;
        forever begin
            @(negedge clk);
            // Live values update on the edge that ends the COMMIT cycle
            if (commit_pend) begin
                commit_pend = 1'b0;
                check("commit_dur", int'({dur_g, dur_y, dur_r}), int'(exp_c));
            end
            if (cfg_commit === 1'b1) begin
                commit_total++;
                if (q_commit.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    exp_c       = q_commit.pop_front();
                    commit_pend = 1'b1;
                end
            end
            if (led !== prev_led) begin
                if (q_led.size() == 0) check("unexpected_led", int'(led), int'(prev_led));
                else                   check("led", int'(led), int'(q_led.pop_front()));
                prev_led = led;
            end
            if (run_en === 1'b1) run_cyc++;
            else                 run_cyc = 0;
            if (tick_1s === 1'b1) begin
                tick_total++;
                check("tick_interval", run_cyc, TICK_DIV);
                run_cyc = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        rst = 1'b1;
        sw  = 2'b00;
        btn = 4'b0000;

        // Reset
        cyc(3);
        check("rst_dur_g", dur_g, 4);
        check("rst_dur_y", dur_y, 1);
        check("rst_dur_r", dur_r, 1);
        check("rst_led", led, 0);
        check("rst_run_en", run_en, 0);
        rst = 1'b0;
        check("rst_wait_run_en", run_en, 0);
        cyc(1);
        check("run_en_cycle2", run_en, 1);
        base = tick_total;
        cyc(32);
        check("tick_count", tick_total - base, 3);

        // Edit green and commit
        q_led.push_back(4'd4);
        sw = 2'b10;
        cyc(4);
        check("edit_run_en", run_en, 0);
        for (int i = 0; i < 3; i++) begin
            q_led.push_back(4'(5 + i));
            press(4'b0001);
        end
        check("edit_dur_g_held", dur_g, 4);
        base = commit_total;
        q_commit.push_back({4'd7, 4'd1, 4'd1});
        q_led.push_back(4'd0);
        sw = 2'b00;
        cyc(6);
        check("commit_pulses", commit_total - base, 1);
        check("commit_dur_g", dur_g, 7);

        // Saturation on yellow
        q_led.push_back(4'd1);
        sw = 2'b01;
        cyc(4);
        press(4'b0010);
        press(4'b0010);
        check("sat_min_led", led, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < 6) q_led.push_back(4'(2 + i));
            press(4'b0001);
        end
        check("sat_max_led", led, 7);
        q_commit.push_back({4'd7, 4'd7, 4'd1});
        q_led.push_back(4'd0);
        sw = 2'b00;
        cyc(6);
        check("sat_dur_y", dur_y, 7);

        // Bounce rejection and restore-all priority
        q_led.push_back(4'd7);
        sw = 2'b10;
        cyc(4);
        btn = 4'b0001;
        cyc(2);
        btn = 4'b0000;
        cyc(10);
        check("glitch_led", led, 7);
        q_led.push_back(4'd6);
        press(4'b0010);
        q_led.push_back(4'd4);
        press(4'b1001);
        q_led.push_back(4'd1);          // yellow shadow restored though live is 7
        sw = 2'b01;
        cyc(4);
        sw = 2'b11;
        cyc(4);
        check("restore_r_led", led, 1);
        q_commit.push_back({4'd4, 4'd1, 4'd1});
        q_led.push_back(4'd0);
        sw = 2'b00;
        cyc(6);

        // Mode hop, then reset mid-edit
        q_led.push_back(4'd1);
        sw = 2'b11;
        cyc(4);
        q_led.push_back(4'd2);
        press(4'b0001);
        q_led.push_back(4'd1);
        sw = 2'b01;
        cyc(4);
        q_led.push_back(4'd2);
        sw = 2'b11;
        cyc(4);
        check("hop_led_kept", led, 2);
        base = commit_total;
        q_led.push_back(4'd0);
        rst = 1'b1;
        sw  = 2'b00;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        check("midrst_dur_r", dur_r, 1);
        check("midrst_dur_g", dur_g, 4);
        check("midrst_dur_y", dur_y, 1);
        check("midrst_no_commit", commit_total - base, 0);
        check("midrst_run_en", run_en, 1);

        cyc(2);
        check("led_queue_drained", q_led.size(), 0);
        check("commit_queue_drained", q_commit.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
